// File: rtl/mcpu_pkg.sv
// Shared MCPU core definitions: datapath defaults, functional-unit codes and the
// reorder-buffer entry layout.
package mcpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned NUM_WB    = 2;
  localparam int unsigned REG_W     = 5;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_LSU = 3'd2,
    FU_BRA = 3'd3,
    FU_CSR = 3'd4
  } fu_type_e;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             regwrite;
    logic             mispredict;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  data;
    logic [XLEN-1:0]  target;
  } rob_entry_t;

endpackage

// File: rtl/rob_wb_match.sv
// Priority match of one ROB tag against all writeback channels; the
// lowest-indexed matching channel is selected.
module rob_wb_match #(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned NUM_WB = 2,
  parameter int unsigned SEL_W  = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
  input  logic [IDX_W-1:0]        i_tag,
  input  logic [NUM_WB-1:0]       i_wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] i_wb_tag,
  output logic                    o_hit,
  output logic [SEL_W-1:0]        o_sel
);

  // Scan from the highest channel down so the lowest index is the last to win.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    for (int i = int'(NUM_WB) - 1; i >= 0; i--) begin
      if (i_wb_valid[i] && (i_wb_tag[i*IDX_W +: IDX_W] == i_tag)) begin
        o_hit = 1'b1;
        o_sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Multi-writeback reorder buffer: in-order dispatch and retire, out-of-order
// completion, precise rollback. Define ROB_WB_BYPASS_EN to forward same-cycle writebacks.
module rob_multiport #(
  parameter int unsigned DEPTH  = mcpu_pkg::ROB_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter int unsigned NUM_WB = mcpu_pkg::NUM_WB,
  parameter int unsigned XLEN   = mcpu_pkg::XLEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic                    disp_regwrite,
  input  logic [4:0]              disp_rd,
  input  logic [XLEN-1:0]         disp_pc,
  output logic [IDX_W-1:0]        disp_tag,
  input  logic [IDX_W-1:0]        rd_tag0,
  input  logic [IDX_W-1:0]        rd_tag1,
  output logic [XLEN-1:0]         rd_data0,
  output logic [XLEN-1:0]         rd_data1,
  output logic                    rd_ready0,
  output logic                    rd_ready1,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_tag,
  input  logic [NUM_WB*XLEN-1:0]  wb_data,
  input  logic [NUM_WB-1:0]       wb_mispredict,
  input  logic [NUM_WB*XLEN-1:0]  wb_target,
  output logic                    commit_valid,
  output logic                    commit_we,
  output logic [4:0]              commit_rd,
  output logic [XLEN-1:0]         commit_data,
  output logic [IDX_W-1:0]        commit_tag,
  output logic                    flush,
  output logic [XLEN-1:0]         flush_pc,
  output logic                    full,
  output logic                    empty
);

  import mcpu_pkg::*;

  localparam int unsigned  SEL_W    = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
  localparam int unsigned  CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  rob_entry_t        r_ent [DEPTH];
  logic [IDX_W-1:0]  r_head;
  logic [IDX_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [DEPTH-1:0]  w_hit;
  logic [SEL_W-1:0]  w_sel [DEPTH];

  logic              w_disp;
  logic              w_commit;
  logic              w_flush;
  logic              w_head_done;
  logic              w_head_mis;
  logic [XLEN-1:0]   w_head_data;
  logic [XLEN-1:0]   w_head_target;

  // One matcher per entry decides which channel (if any) completes that entry.
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_ent_match
    rob_wb_match #(
      .IDX_W  (IDX_W),
      .NUM_WB (NUM_WB),
      .SEL_W  (SEL_W)
    ) u_ent_match (
      .i_tag      (IDX_W'(g)),
      .i_wb_valid (wb_valid),
      .i_wb_tag   (wb_tag),
      .o_hit      (w_hit[g]),
      .o_sel      (w_sel[g])
    );
  end

  // Head view; the bypass build also sees a writeback landing on the head this cycle.
  always_comb begin
    w_head_done   = r_ent[r_head].done;
    w_head_mis    = r_ent[r_head].mispredict;
    w_head_data   = r_ent[r_head].data;
    w_head_target = r_ent[r_head].target;
`ifdef ROB_WB_BYPASS_EN
    if (w_hit[r_head] && r_ent[r_head].busy && !r_ent[r_head].done) begin
      w_head_done   = 1'b1;
      w_head_mis    = wb_mispredict[w_sel[r_head]];
      w_head_data   = wb_data[int'(w_sel[r_head])*XLEN +: XLEN];
      w_head_target = wb_target[int'(w_sel[r_head])*XLEN +: XLEN];
    end
`endif
  end

  assign empty      = (r_count == '0);
  assign full       = (r_count == CNT_FULL);
  assign w_commit   = !empty && w_head_done;
  assign w_flush    = w_commit && w_head_mis;
  assign disp_ready = !full && !w_flush;
  assign w_disp     = disp_valid && disp_ready;

  assign disp_tag     = r_tail;
  assign commit_valid = w_commit;
  assign commit_we    = w_commit && r_ent[r_head].regwrite;
  assign commit_rd    = r_ent[r_head].rd;
  assign commit_data  = w_head_data;
  assign commit_tag   = r_head;
  assign flush        = w_flush;
  assign flush_pc     = w_flush ? w_head_target : '0;

`ifdef ROB_WB_BYPASS_EN
  logic             w_rd_hit0;
  logic             w_rd_hit1;
  logic [SEL_W-1:0] w_rd_sel0;
  logic [SEL_W-1:0] w_rd_sel1;

  rob_wb_match #(
    .IDX_W  (IDX_W),
    .NUM_WB (NUM_WB),
    .SEL_W  (SEL_W)
  ) u_rd0_match (
    .i_tag      (rd_tag0),
    .i_wb_valid (wb_valid),
    .i_wb_tag   (wb_tag),
    .o_hit      (w_rd_hit0),
    .o_sel      (w_rd_sel0)
  );

  rob_wb_match #(
    .IDX_W  (IDX_W),
    .NUM_WB (NUM_WB),
    .SEL_W  (SEL_W)
  ) u_rd1_match (
    .i_tag      (rd_tag1),
    .i_wb_valid (wb_valid),
    .i_wb_tag   (wb_tag),
    .o_hit      (w_rd_hit1),
    .o_sel      (w_rd_sel1)
  );
`endif

  // Operand lookup for issue.
  always_comb begin
    rd_ready0 = r_ent[rd_tag0].busy && r_ent[rd_tag0].done;
    rd_data0  = r_ent[rd_tag0].data;
    rd_ready1 = r_ent[rd_tag1].busy && r_ent[rd_tag1].done;
    rd_data1  = r_ent[rd_tag1].data;
`ifdef ROB_WB_BYPASS_EN
    if (w_rd_hit0 && r_ent[rd_tag0].busy && !r_ent[rd_tag0].done && !w_flush) begin
      rd_ready0 = 1'b1;
      rd_data0  = wb_data[int'(w_rd_sel0)*XLEN +: XLEN];
    end
    if (w_rd_hit1 && r_ent[rd_tag1].busy && !r_ent[rd_tag1].done && !w_flush) begin
      rd_ready1 = 1'b1;
      rd_data1  = wb_data[int'(w_rd_sel1)*XLEN +: XLEN];
    end
`endif
  end

  // Entry state and pointers; a flush discards every in-flight entry and writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int e = 0; e < int'(DEPTH); e++) begin
        r_ent[e] <= '0;
      end
    end else if (w_flush) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        r_ent[e].busy       <= 1'b0;
        r_ent[e].done       <= 1'b0;
        r_ent[e].mispredict <= 1'b0;
      end
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        if (w_hit[e] && r_ent[e].busy) begin
          r_ent[e].done       <= 1'b1;
          r_ent[e].data       <= wb_data[int'(w_sel[e])*XLEN +: XLEN];
          r_ent[e].mispredict <= wb_mispredict[w_sel[e]];
          r_ent[e].target     <= wb_target[int'(w_sel[e])*XLEN +: XLEN];
        end
      end
      if (w_commit) begin
        r_ent[r_head].busy       <= 1'b0;
        r_ent[r_head].done       <= 1'b0;
        r_ent[r_head].mispredict <= 1'b0;
        r_head                   <= r_head + IDX_W'(1);
      end
      if (w_disp) begin
        r_ent[r_tail].busy       <= 1'b1;
        r_ent[r_tail].done       <= 1'b0;
        r_ent[r_tail].mispredict <= 1'b0;
        r_ent[r_tail].regwrite   <= disp_regwrite;
        r_ent[r_tail].rd         <= disp_rd;
        r_ent[r_tail].pc         <= disp_pc;
        r_ent[r_tail].data       <= '0;
        r_ent[r_tail].target     <= '0;
        r_tail                   <= r_tail + IDX_W'(1);
      end
      r_count <= r_count + CNT_W'(w_disp) - CNT_W'(w_commit);
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport (DEPTH=8, NUM_WB=2, XLEN=32, bypass disabled).
module tb_rob_multiport;

  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int NUM_WB = 2;
  localparam int XLEN   = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    disp_valid;
  logic                    disp_ready;
  logic                    disp_regwrite;
  logic [4:0]              disp_rd;
  logic [XLEN-1:0]         disp_pc;
  logic [IDX_W-1:0]        disp_tag;
  logic [IDX_W-1:0]        rd_tag0, rd_tag1;
  logic [XLEN-1:0]         rd_data0, rd_data1;
  logic                    rd_ready0, rd_ready1;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*IDX_W-1:0] wb_tag;
  logic [NUM_WB*XLEN-1:0]  wb_data;
  logic [NUM_WB-1:0]       wb_mispredict;
  logic [NUM_WB*XLEN-1:0]  wb_target;
  logic                    commit_valid, commit_we;
  logic [4:0]              commit_rd;
  logic [XLEN-1:0]         commit_data;
  logic [IDX_W-1:0]        commit_tag;
  logic                    flush;
  logic [XLEN-1:0]         flush_pc;
  logic                    full, empty;

  int checks = 0;
  int errors = 0;

  rob_multiport #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_regwrite(disp_regwrite),
    .disp_rd(disp_rd), .disp_pc(disp_pc), .disp_tag(disp_tag),
    .rd_tag0(rd_tag0), .rd_tag1(rd_tag1), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rd_ready0(rd_ready0), .rd_ready1(rd_ready1),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .flush(flush), .flush_pc(flush_pc), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_mispredict = '0; wb_target = '0;
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0; disp_regwrite = 1'b0; disp_rd = '0; disp_pc = '0;
    rd_tag0 = '0; rd_tag1 = '0;
    clear_wb();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic put_wb(input int ch, input logic [IDX_W-1:0] tag, input logic [XLEN-1:0] d,
                        input logic mis, input logic [XLEN-1:0] tgt);
    wb_valid[ch]                 = 1'b1;
    wb_tag[ch*IDX_W +: IDX_W]    = tag;
    wb_data[ch*XLEN +: XLEN]     = d;
    wb_mispredict[ch]            = mis;
    wb_target[ch*XLEN +: XLEN]   = tgt;
  endtask

  task automatic dispatch_n(input int n);
    for (int i = 0; i < n; i++) begin
      disp_valid = 1'b1; disp_regwrite = 1'b1;
      disp_rd = 5'(i + 1); disp_pc = 32'h1000 + 32'(4 * i);
      tick();
    end
    disp_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
    checks++; if (disp_tag !== 3'd0) begin errors++; $display("FAIL reset_disp_tag: got %0d want 0", disp_tag); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid: got %b want 0", commit_valid); end
    checks++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin errors++; $display("FAIL reset_flush: got %b/%h want 0/0", flush, flush_pc); end
    checks++; if (rd_ready0 !== 1'b0 || rd_data0 !== 32'h0) begin errors++; $display("FAIL reset_rd0: got %b/%h want 0/0", rd_ready0, rd_data0); end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      disp_valid = 1'b1; disp_regwrite = 1'b1; disp_rd = 5'(i); disp_pc = 32'(i * 4);
      #1;
      checks++; if (disp_tag !== 3'(i)) begin errors++; $display("FAIL fill_tag%0d: got %0d want %0d", i, disp_tag, i); end
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", i, disp_ready); end
      tick();
    end
    disp_valid = 1'b0;
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL fill_disp_ready: got %b want 0", disp_ready); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", empty); end
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    rd_tag0 = 3'd3;
    #1;
    checks++; if (disp_tag !== 3'd0) begin errors++; $display("FAIL fill_ninth_tag: got %0d want 0", disp_tag); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_ninth_full: got %b want 1", full); end
    checks++; if (rd_ready0 !== 1'b0) begin errors++; $display("FAIL fill_busy_not_done: got %b want 0", rd_ready0); end
  endtask

  task automatic test_inorder_commit();
    do_reset();
    dispatch_n(3);
    put_wb(0, 3'd2, 32'h33, 1'b0, 32'h0);
    tick();
    clear_wb();
    rd_tag0 = 3'd2;
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL io_no_commit_tag2: got %b want 0", commit_valid); end
    checks++; if (rd_ready0 !== 1'b1 || rd_data0 !== 32'h33) begin errors++; $display("FAIL io_lookup_tag2: got %b/%h want 1/33", rd_ready0, rd_data0); end
    put_wb(0, 3'd0, 32'h11, 1'b0, 32'h0);
    #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL io_wb_same_cycle: got %b want 0", commit_valid); end
    tick();
    clear_wb();
    #1;
    checks++; if (commit_valid !== 1'b1 || commit_data !== 32'h11 || commit_tag !== 3'd0) begin
      errors++; $display("FAIL io_commit0: got v=%b d=%h t=%0d want 1/11/0", commit_valid, commit_data, commit_tag); end
    checks++; if (commit_rd !== 5'd1 || commit_we !== 1'b1) begin errors++; $display("FAIL io_commit0_rd: got rd=%0d we=%b want 1/1", commit_rd, commit_we); end
    tick();
    checks++; if (commit_valid !== 1'b0 || commit_tag !== 3'd1) begin errors++; $display("FAIL io_tag1_blocks: got v=%b t=%0d want 0/1", commit_valid, commit_tag); end
    put_wb(1, 3'd1, 32'h22, 1'b0, 32'h0);
    tick();
    clear_wb();
    #1;
    checks++; if (commit_valid !== 1'b1 || commit_data !== 32'h22) begin errors++; $display("FAIL io_commit1: got v=%b d=%h want 1/22", commit_valid, commit_data); end
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_data !== 32'h33 || commit_tag !== 3'd2) begin
      errors++; $display("FAIL io_commit2: got v=%b d=%h t=%0d want 1/33/2", commit_valid, commit_data, commit_tag); end
    tick();
    checks++; if (empty !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL io_drained: got e=%b v=%b want 1/0", empty, commit_valid); end
  endtask

  task automatic test_dual_wb();
    do_reset();
    dispatch_n(4);
    put_wb(0, 3'd1, 32'hAA, 1'b0, 32'h0);
    put_wb(1, 3'd3, 32'hBB, 1'b0, 32'h0);
    tick();
    clear_wb();
    rd_tag0 = 3'd1; rd_tag1 = 3'd3;
    #1;
    checks++; if (rd_ready0 !== 1'b1 || rd_data0 !== 32'hAA) begin errors++; $display("FAIL dual_port0: got %b/%h want 1/aa", rd_ready0, rd_data0); end
    checks++; if (rd_ready1 !== 1'b1 || rd_data1 !== 32'hBB) begin errors++; $display("FAIL dual_port1: got %b/%h want 1/bb", rd_ready1, rd_data1); end
    rd_tag0 = 3'd2;
    #1;
    checks++; if (rd_ready0 !== 1'b0) begin errors++; $display("FAIL dual_tag2_pending: got %b want 0", rd_ready0); end
    put_wb(0, 3'd2, 32'h01, 1'b0, 32'h0);
    put_wb(1, 3'd2, 32'h02, 1'b0, 32'h0);
    tick();
    clear_wb();
    #1;
    checks++; if (rd_ready0 !== 1'b1 || rd_data0 !== 32'h01) begin errors++; $display("FAIL dual_same_tag: got %b/%h want 1/01", rd_ready0, rd_data0); end
    put_wb(0, 3'd5, 32'h55, 1'b0, 32'h0);
    tick();
    clear_wb();
    rd_tag1 = 3'd5;
    #1;
    checks++; if (rd_ready1 !== 1'b0) begin errors++; $display("FAIL dual_nonbusy_ignored: got %b want 0", rd_ready1); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL dual_head_blocks: got %b want 0", commit_valid); end
  endtask

  task automatic test_mispredict();
    do_reset();
    dispatch_n(6);
    put_wb(0, 3'd0, 32'h10, 1'b0, 32'h0);
    put_wb(1, 3'd1, 32'h44, 1'b1, 32'h100);
    tick();
    clear_wb();
    #1;
    checks++; if (commit_valid !== 1'b1 || flush !== 1'b0 || commit_data !== 32'h10) begin
      errors++; $display("FAIL mp_commit0: got v=%b f=%b d=%h want 1/0/10", commit_valid, flush, commit_data); end
    tick();
    disp_valid = 1'b1;
    put_wb(0, 3'd2, 32'h99, 1'b0, 32'h0);
    #1;
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h100) begin errors++; $display("FAIL mp_flush: got %b/%h want 1/100", flush, flush_pc); end
    checks++; if (commit_valid !== 1'b1 || commit_tag !== 3'd1 || commit_data !== 32'h44 || commit_we !== 1'b1) begin
      errors++; $display("FAIL mp_link_commit: got v=%b t=%0d d=%h we=%b want 1/1/44/1", commit_valid, commit_tag, commit_data, commit_we); end
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL mp_disp_blocked: got %b want 0", disp_ready); end
    tick();
    disp_valid = 1'b0;
    clear_wb();
    rd_tag0 = 3'd2;
    #1;
    checks++; if (flush !== 1'b0 || flush_pc !== 32'h0) begin errors++; $display("FAIL mp_flush_pulse: got %b/%h want 0/0", flush, flush_pc); end
    checks++; if (empty !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL mp_empty: got e=%b v=%b want 1/0", empty, commit_valid); end
    checks++; if (disp_tag !== 3'd6 || commit_tag !== 3'd6) begin errors++; $display("FAIL mp_head_eq_tail: got tail=%0d head=%0d want 6/6", disp_tag, commit_tag); end
    checks++; if (rd_ready0 !== 1'b0) begin errors++; $display("FAIL mp_wb_discarded: got %b want 0", rd_ready0); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 22; k++) begin
      clear_wb();
      disp_valid = (k < 20); disp_regwrite = 1'b1; disp_rd = 5'(k); disp_pc = 32'(k);
      if (k >= 1 && k <= 20) put_wb(k % 2, 3'((k - 1) % DEPTH), 32'hC000 + 32'(k - 1), 1'b0, 32'h0);
      #1;
      if (k < 20) begin
        checks++; if (disp_tag !== 3'(k % DEPTH)) begin errors++; $display("FAIL wrap_tag k=%0d: got %0d want %0d", k, disp_tag, k % DEPTH); end
      end
      checks++; if (commit_valid !== (k >= 2)) begin errors++; $display("FAIL wrap_cv k=%0d: got %b want %b", k, commit_valid, (k >= 2)); end
      if (k >= 2) begin
        checks++; if (commit_data !== 32'hC000 + 32'(k - 2) || commit_tag !== 3'((k - 2) % DEPTH)) begin
          errors++; $display("FAIL wrap_commit k=%0d: got d=%h t=%0d want %h/%0d", k, commit_data, commit_tag, 32'hC000 + 32'(k - 2), (k - 2) % DEPTH); end
      end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full k=%0d: got %b want 0", k, full); end
      tick();
    end
    disp_valid = 1'b0;
    clear_wb();
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
  endtask

  task automatic test_full_commit_and_reset();
    do_reset();
    dispatch_n(8);
    put_wb(0, 3'd0, 32'h77, 1'b0, 32'h0);
    tick();
    clear_wb();
    disp_valid = 1'b1;
    #1;
    checks++; if (commit_valid !== 1'b1 || full !== 1'b1 || disp_ready !== 1'b0) begin
      errors++; $display("FAIL fc_refuse: got v=%b full=%b rdy=%b want 1/1/0", commit_valid, full, disp_ready); end
    tick();
    #1;
    checks++; if (full !== 1'b0 || disp_tag !== 3'd0) begin errors++; $display("FAIL fc_after_commit: got full=%b tag=%0d want 0/0", full, disp_tag); end
    tick();
    disp_valid = 1'b0;
    put_wb(1, 3'd1, 32'h5, 1'b1, 32'h200);
    tick();
    clear_wb();
    #1;
    checks++; if (full !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL fc_prereset: got full=%b flush=%b want 1/1", full, flush); end
    rst = 1'b1;
    #1;
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL arst_empty: got e=%b f=%b want 1/0", empty, full); end
    checks++; if (commit_valid !== 1'b0 || flush !== 1'b0 || flush_pc !== 32'h0) begin
      errors++; $display("FAIL arst_outputs: got v=%b f=%b pc=%h want 0/0/0", commit_valid, flush, flush_pc); end
    checks++; if (disp_tag !== 3'd0 || disp_ready !== 1'b1) begin errors++; $display("FAIL arst_tail: got tag=%0d rdy=%b want 0/1", disp_tag, disp_ready); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_inorder_commit();
    test_dual_wb();
    test_mispredict();
    test_wrap();
    test_full_commit_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised reorder buffer for the out-of-order MCPU core; successor to the single-writeback ROB.
- Sits between issue (RAT/decoder) and the register file.
- Allocates in-order entries at dispatch, accepts out-of-order results from NUM_WB writeback (CDB) channels, serves two operand lookups for issue, and retires one entry per cycle in order.
- Performs precise rollback on a mispredicted branch reaching the head.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- IDX_W, $clog2(DEPTH), entry tag width.
- NUM_WB, 2, number of writeback channels.
- XLEN, 32, data and PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  dispatch accepted this cycle; equals ~full & ~flush.
- disp_regwrite  in  1  instruction writes rd.
- disp_rd  in  5  destination register.
- disp_pc  in  XLEN  instruction PC.
- disp_tag  out  IDX_W  tag allocated; equals the tail pointer.
- rd_tag0, rd_tag1  in  IDX_W  operand lookup tags, supplied by the RAT.
- rd_data0, rd_data1  out  XLEN  entry result.
- rd_ready0, rd_ready1  out  1  entry busy and done.
- wb_valid  in  NUM_WB  per-channel result strobe.
- wb_tag  in  NUM_WB*IDX_W  packed tags.
- wb_data  in  NUM_WB*XLEN  packed results.
- wb_mispredict  in  NUM_WB  result is a mispredicted branch or jump.
- wb_target  in  NUM_WB*XLEN  correct next PC when mispredicted.
- commit_valid  out  1  head retires this cycle.
- commit_we  out  1  commit_valid & regwrite of head.
- commit_rd  out  5  head rd.
- commit_data  out  XLEN  head result.
- commit_tag  out  IDX_W  head tag; used by the RAT to clear its mapping.
- flush  out  1  rollback pulse.
- flush_pc  out  XLEN  redirect PC.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage: circular buffer with head, tail, and count (width IDX_W+1).
- Per-entry state: busy, done, regwrite, mispredict, rd, pc, data, target.
- Pointers wrap modulo DEPTH.
- Reset (async): head=tail=count=0; all busy/done cleared; empty=1, disp_ready=1.
  - All other outputs are 0, including disp_tag, commit_*, flush, flush_pc, rd_*.
- Dispatch: on an edge with disp_valid & disp_ready:
  - entry[tail] gets busy=1, done=0, mispredict=0, fields from the inputs.
  - tail advances.
  - Entries do not require disp_valid to be held.
- Writeback: for each channel i with wb_valid[i] and busy[wb_tag[i]]:
  - set done=1 and store data, mispredict, target.
  - Writeback to a non-busy tag is ignored.
  - Two channels writing the same tag in one cycle is illegal; the lowest-indexed channel wins.
- Operand lookup: combinational.
  - rd_readyN = busy[tag] & done[tag].
  - rd_dataN = data[tag].
- Commit (combinational decision):
  - commit_valid = ~empty & done[head].
  - The head entry is cleared and head advances at the edge.
  - Retirement is limited to one entry per cycle.
- Rollback:
  - Triggered when the committing head has mispredict=1.
  - flush=1 and flush_pc=target[head] in the same cycle; the head still commits its rd (jal/jalr link).
  - At the edge, all busy/done are cleared, head=tail, count=0.
- Simultaneous events:
  - Dispatch and commit in one cycle leave count unchanged.
  - When full, dispatch is refused even if commit frees an entry that cycle.
  - Writeback landing on the head in the same cycle does not commit until the next cycle (done is registered).
  - During flush, dispatch is blocked and writebacks are discarded.
- Reset mid-operation discards all entries immediately; no commit or flush is emitted.

Optional Feature:
- Macro: ROB_WB_BYPASS_EN.
- When defined: operand lookup and commit also see same-cycle writebacks.
  - rd_readyN/rd_dataN forward a matching wb channel (lowest index wins).
  - The head may commit in the writeback cycle, including triggering flush.
- When undefined: results are visible only the cycle after writeback.

Decomposition:
- Shared package mcpu_pkg:
  - XLEN, ROB_DEPTH, NUM_WB defaults.
  - Entry struct typedef rob_entry_t.
  - FU type constants (FU_BRA etc.).
- One sub-module, rob_wb_match: per-entry, priority-encodes which wb channel hits a given tag.
  - Instantiated per entry and per lookup port.

Test Plan:
- Reset then dispatch 8 (DEPTH=8) → disp_tag 0..7, full=1 after 8th, disp_ready=0; 9th request ignored.
- Dispatch tags 0,1,2; wb tag2=0x33 then tag0=0x11 → commit_valid only after tag0 done, commit order 0x11 (tag0); tag1 blocks until written.
- NUM_WB=2 same-cycle wb tag1=0xAA and tag3=0xBB → next cycle rd_tag0=1 gives 0xAA ready, rd_tag1=3 gives 0xBB ready.
- Entry tag1 mispredict target=0x100 with tags 2..5 busy → commit tag1, flush=1, flush_pc=0x100 for one cycle; next cycle empty=1, head=tail.
- Wrap: 20 dispatch/commit pairs at DEPTH=8 → tags wrap 7→0, count never exceeds 8, commit data matches dispatch order.
- Assert rst while full mid-run → empty=1, commit_valid=0, flush=0 immediately (asynchronously).
